// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: start/busy/done handshake plus data.
// With SERIAL_SUBTRACTOR_OVF_EN defined the bundle also carries the signed-overflow flag.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
`else
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
`endif

endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor step per clock.
// Optional SERIAL_SUBTRACTOR_OVF_EN adds a registered signed-overflow flag (ovf).
//
// state | meaning
// IDLE  | waiting for start; last result held
// RUN   | one bit processed per edge, busy=1
// DONE  | one-cycle done pulse; start here is accepted like IDLE
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Single full-subtractor cell on the current LSBs of the operand shifters.
  assign d_bit    = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign res_next = {d_bit, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      br   <= bus.bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      br     <= br_next;
      res_sh <= res_next;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        diff_q <= res_next;
        bout_q <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        // On the final step the shifter LSBs are the operand sign bits and d_bit is diff's MSB.
        ovf_q  <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
`endif
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor; the inverse-operation counterpart to the team's ripple-carry adders.
- Computes diff = a - b - bin, LSB first, one bit per clock through a single full-subtractor cell.
- Uses a start/busy/done handshake, so it can share an operand bus with the adder datapath in area-constrained arithmetic units.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; operands are sampled on the edge where start=1 and the block is idle or done
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  registered difference; held until the next accepted start
- bout  output  1  registered borrow-out; held with diff

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0: state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, operand shift registers=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a, b, bin into shift registers, clear the bit counter, go to RUN.
  - RUN: each edge processes bit i with the current borrow br:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the MSB of the result register (right-shift accumulation).
    - The counter increments; after the WIDTH-th bit, go to DONE, loading diff and bout = final borrow.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE and goes to RUN; otherwise go to IDLE.
- busy=1 exactly in RUN; done=1 exactly in DONE. Both are registered (no combinational path from start).
- Latency: start sampled at edge E0 → busy high after E0 → done high after edge E(WIDTH). diff and bout change only on the transition into DONE.
- start while in RUN: ignored. Operands and result are unaffected; no queueing.
- a, b and bin may change freely after the accepting edge; only the latched copies are used.
- diff and bout keep the last result through IDLE and during the next RUN. They update only at the next completion.
- Arithmetic is modulo 2^WIDTH. bout=1 if and only if a < b + bin as unsigned values.
- Reset mid-operation: abort immediately with all outputs at their reset values. No done pulse is produced for the aborted operation.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), registered alongside diff.
  - ovf = signed overflow of a - b - bin in two's complement = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), evaluated on the latched operands.
  - Reset value 0; held like diff.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4. Reset, then start with a=14, b=10, bin=1 → done exactly 4 cycles after the accepting edge, busy high for those 4 cycles; diff=3, bout=0.
- Back-to-back via DONE-state start:
  - a=8, b=9, bin=0 → diff=15, bout=1.
  - Start asserted in the DONE cycle with a=15, b=3, bin=0 → no IDLE cycle; second done after 4 more cycles with diff=12, bout=0.
- Borrow-in propagation: a=1, b=6, bin=1 → diff=10, bout=1. With SERIAL_SUBTRACTOR_OVF_EN defined: a=7, b=12, bin=0 → diff=11, bout=1, ovf=1.
- start held high and operands changed to a=0, b=0 throughout RUN after accepting a=9, b=2, bin=1 → result diff=6, bout=0; no restart until the DONE cycle.
- rst_n pulsed low for 1 cycle during the 2nd RUN cycle of a=7, b=12 → immediately busy=0, done=0, diff=0, bout=0. No done pulse follows; a fresh start afterwards completes normally.
- Edge values: a=0, b=15, bin=1 → diff=0, bout=1. a=15, b=0, bin=0 → diff=15, bout=0.
